tlb_refill_walker: RTL



---
 rtl/tlb_refill_walker.sv | 112 +++++++++++
 1 files changed

// File: rtl/tlb_refill_walker.sv
// tlb_refill_walker: two-level page-table walker that refills one TLB entry pair per miss
module tlb_refill_walker #(
  parameter int TLB_LINE  = 32,
  parameter int TLB_WIDTH = 5,
  parameter int WIRED     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  logic [31:0]          miss_vaddr,
  input  logic [7:0]           miss_asid,
  input  logic [19:0]          pgd_base,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 tlb_we,
  output logic [TLB_WIDTH-1:0] tlb_index,
  output logic [31:0]          tlb_entryhi,
  output logic [31:0]          tlb_entrylo0,
  output logic [31:0]          tlb_entrylo1,
  output logic [31:0]          tlb_pagemask,
  output logic                 resp_valid,
  output logic                 resp_fault
);
  typedef enum logic [2:0] {IDLE, RD_PDE, RD_PTE0, RD_PTE1, WRITE, FAULT, DRAIN} state_t;
  state_t state, state_n;
  logic [18:0] vpn_q;
  logic [7:0] asid_q;
  logic [19:0] pgd_q;
  logic [19:0] pde_frame_q;
  logic [30:0] lo0_q;
  logic g0_q;
  logic [TLB_WIDTH-1:0] ptr_q;
  logic accept;
  logic rd;
  logic g;
  logic unused_ok;
  // EntryLo without its G bit: frame, cacheability from the PTE no-cache bit, D, V
  function automatic logic [30:0] lo_base(input logic [19:0] frame, input logic [2:0] cdv);
    return {6'b0, frame, cdv[2] ? 3'b010 : 3'b011, cdv[1], cdv[0]};
  endfunction
  assign accept = state == IDLE && miss_valid;
  assign rd = state == RD_PDE || state == RD_PTE0 || state == RD_PTE1;
  assign g = g0_q & mem_rdata[8];
  assign unused_ok = ^{miss_vaddr[12:0], mem_rdata[11:9], mem_rdata[7:3]};
  // state register; async reset abandons any walk in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: a flush without ack must drain the outstanding read before going idle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = miss_valid ? RD_PDE : IDLE;
      RD_PDE:  state_n = mem_ack ? (flush ? IDLE : mem_rdata[0] ? RD_PTE0 : FAULT) : flush ? DRAIN : RD_PDE;
      RD_PTE0: state_n = mem_ack ? (flush ? IDLE : RD_PTE1) : flush ? DRAIN : RD_PTE0;
      RD_PTE1: state_n = mem_ack ? (flush ? IDLE : WRITE) : flush ? DRAIN : RD_PTE1;
      WRITE:   state_n = IDLE;
      FAULT:   state_n = IDLE;
      DRAIN:   state_n = mem_ack ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // walk datapath: request capture, PDE/PTE latches, entry build and replacement pointer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vpn_q <= '0;
      asid_q <= '0;
      pgd_q <= '0;
      pde_frame_q <= '0;
      lo0_q <= '0;
      g0_q <= 1'b0;
      ptr_q <= TLB_WIDTH'(WIRED);
      tlb_entryhi <= '0;
      tlb_entrylo0 <= '0;
      tlb_entrylo1 <= '0;
    end else begin
      if (accept) begin
        vpn_q <= miss_vaddr[31:13];
        asid_q <= miss_asid;
        pgd_q <= pgd_base;
      end
      if (state == RD_PDE && mem_ack) pde_frame_q <= mem_rdata[31:12];
      if (state == RD_PTE0 && mem_ack) begin
        lo0_q <= lo_base(mem_rdata[31:12], mem_rdata[2:0]);
        g0_q <= mem_rdata[8];
      end
      if (state == RD_PTE1 && mem_ack && !flush) begin
        tlb_entryhi <= {vpn_q, 5'b0, asid_q};
        tlb_entrylo0 <= {lo0_q, g};
        tlb_entrylo1 <= {lo_base(mem_rdata[31:12], mem_rdata[2:0]), g};
      end
      if (state == WRITE)
        ptr_q <= ptr_q == TLB_WIDTH'(TLB_LINE - 1) ? TLB_WIDTH'(WIRED) : ptr_q + TLB_WIDTH'(1);
    end
  // outputs decoded from state; read address is a pure function of latched walk state
  always_comb begin
    miss_ready = state == IDLE;
    mem_req = rd;
    mem_addr = state == RD_PDE  ? {pgd_q, vpn_q[18:9], 2'b00} :
               state == RD_PTE0 ? {pde_frame_q, vpn_q[8:0], 3'b000} :
               state == RD_PTE1 ? {pde_frame_q, vpn_q[8:0], 3'b100} : 32'h0;
    tlb_we = state == WRITE;
    tlb_index = ptr_q;
    tlb_pagemask = 32'h0;
    resp_valid = state == WRITE || state == FAULT;
    resp_fault = state == FAULT;
  end
endmodule
